// File: rtl/framebuffer_pixel_writer_pkg.sv
// framebuffer_pixel_writer_pkg: screen constants, RGB332 packing and master FSM states
package framebuffer_pixel_writer_pkg;
  localparam int CORDW = 10;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  typedef enum logic {IDLE, WRITE} state_e;
  function automatic logic [7:0] pack_rgb332(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction
endpackage

// File: rtl/framebuffer_pixel_writer_pixel_fifo.sv
// pixel_fifo: synchronous FIFO of {addr, data}; push and pop may coincide, including when full
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 27
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/framebuffer_pixel_writer.sv
// framebuffer_pixel_writer: filters and packs raymarcher pixels, queues them and
// writes them to the frame buffer as an Avalon-MM master
module framebuffer_pixel_writer
  import framebuffer_pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_W        = 19,
  parameter int BASE_ADDR     = 0,
  parameter int SCREEN_WIDTH  = framebuffer_pixel_writer_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = framebuffer_pixel_writer_pkg::SCREEN_HEIGHT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_enable,
  input  logic                          i_valid,
  input  logic [CORDW-1:0]              i_pixel_x,
  input  logic [CORDW-1:0]              i_pixel_y,
  input  logic [7:0]                    i_red,
  input  logic [7:0]                    i_green,
  input  logic [7:0]                    i_blue,
  output logic [ADDR_W-1:0]             o_address,
  output logic                          o_write,
  output logic [7:0]                    o_writedata,
  input  logic                          i_waitrequest,
  output logic                          o_frame_done,
  output logic [15:0]                   o_overflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int DW = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(BASE_ADDR + (SCREEN_HEIGHT - 1) * SCREEN_WIDTH + SCREEN_WIDTH - 1);
  logic stage_valid_q, stage_valid_d, frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d, address_q, address_d;
  logic [7:0] stage_data_q, stage_data_d, writedata_q, writedata_d;
  logic [15:0] ovf_q, ovf_d;
  state_e state_q, state_d;
  logic push, pop, full, empty;
  logic [DW-1:0] fifo_rdata;
  logic [31:0] lin;
  always_comb begin
    // shift-add form of y*640 avoids a multiplier at the default resolution
    lin = (SCREEN_WIDTH == 640) ? (32'(i_pixel_y) << 9) + (32'(i_pixel_y) << 7) + 32'(i_pixel_x)
                                : 32'(i_pixel_y) * 32'(SCREEN_WIDTH) + 32'(i_pixel_x);
    stage_valid_d = i_valid && i_enable && 32'(i_pixel_x) < 32'(SCREEN_WIDTH)
                    && 32'(i_pixel_y) < 32'(SCREEN_HEIGHT);
    stage_addr_d  = ADDR_W'(32'(BASE_ADDR) + lin);
    stage_data_d  = pack_rgb332(i_red, i_green, i_blue);
    pop           = !empty && (state_q == IDLE || !i_waitrequest);
    push          = stage_valid_q && (!full || pop);
    ovf_d         = (stage_valid_q && full && !pop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    state_d       = pop ? WRITE : (state_q == WRITE && !i_waitrequest) ? IDLE : state_q;
    address_d     = pop ? fifo_rdata[DW-1:8] : address_q;
    writedata_d   = pop ? fifo_rdata[7:0] : writedata_q;
    frame_done_d  = state_q == WRITE && !i_waitrequest && address_q == LAST_ADDR;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      ovf_q         <= '0;
      state_q       <= IDLE;
      address_q     <= '0;
      writedata_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      ovf_q         <= ovf_d;
      state_q       <= state_d;
      address_q     <= address_d;
      writedata_q   <= writedata_d;
      frame_done_q  <= frame_done_d;
    end
  end
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .wdata({stage_addr_q, stage_data_q}), .rdata(fifo_rdata),
    .full(full), .empty(empty), .level(o_fifo_level)
  );
  assign o_write          = state_q == WRITE;
  assign o_address        = address_q;
  assign o_writedata      = writedata_q;
  assign o_frame_done     = frame_done_q;
  assign o_overflow_count = ovf_q;
endmodule

// File: tb/tb_framebuffer_pixel_writer.sv
// tb_framebuffer_pixel_writer: directed stimulus with a write scoreboard and per-cycle monitor
module tb_framebuffer_pixel_writer;
  logic clk, reset_n, i_enable, i_valid, i_waitrequest;
  logic [9:0] i_pixel_x, i_pixel_y;
  logic [7:0] i_red, i_green, i_blue, o_writedata;
  logic [18:0] o_address;
  logic o_write, o_frame_done;
  logic [15:0] o_overflow_count;
  logic [4:0] o_fifo_level;
  logic [26:0] sb[$];
  int n_assert = 0, n_fail = 0, writes_seen = 0, fd_pulses = 0, base = 0;
  bit fd_exp = 0;
  localparam logic [18:0] LAST = 19'd307199;

  framebuffer_pixel_writer dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_valid(i_valid),
    .i_pixel_x(i_pixel_x), .i_pixel_y(i_pixel_y), .i_red(i_red), .i_green(i_green),
    .i_blue(i_blue), .o_address(o_address), .o_write(o_write), .o_writedata(o_writedata),
    .i_waitrequest(i_waitrequest), .o_frame_done(o_frame_done),
    .o_overflow_count(o_overflow_count), .o_fifo_level(o_fifo_level)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input bit en, input bit keep);
    @(negedge clk);
    i_valid = 1; i_enable = en;
    i_pixel_x = 10'(x); i_pixel_y = 10'(y);
    i_red = r; i_green = g; i_blue = b;
    if (keep && en && x < 640 && y < 480) sb.push_back({19'(y * 640 + x), r[7:5], g[7:5], b[7:6]});
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 0; i_enable = 1;
  endtask

  task automatic nxt();
    @(negedge clk);
    #4;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 200 && writes_seen < n; i++) nxt();
    chk("write_count", writes_seen, n);
  endtask

  // monitor samples just before each rising edge, when inputs have settled
  always @(negedge clk) begin
    #3;
    if (!reset_n) fd_exp = 0;
    else begin
      chk("frame_done", o_frame_done, fd_exp);
      if (o_frame_done) fd_pulses++;
      fd_exp = 0;
      if (o_write) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("wr_addr", o_address, sb[0][26:8]);
          chk("wr_data", o_writedata, sb[0][7:0]);
          if (!i_waitrequest) begin
            fd_exp = sb[0][26:8] == LAST;
            void'(sb.pop_front());
            writes_seen++;
          end
        end
      end
    end
  end

  initial begin
    reset_n = 0; i_enable = 1; i_valid = 0; i_waitrequest = 0;
    i_pixel_x = 0; i_pixel_y = 0; i_red = 0; i_green = 0; i_blue = 0;
    #12;
    chk("rst_write", o_write, 0);
    chk("rst_addr", o_address, 0);
    chk("rst_data", o_writedata, 0);
    chk("rst_fd", o_frame_done, 0);
    chk("rst_ovf", o_overflow_count, 0);
    chk("rst_level", o_fifo_level, 0);
    @(negedge clk); reset_n = 1;

    // single sample latency
    base = writes_seen;
    send(3, 2, 8'hFF, 8'h00, 8'hFF, 1, 1);
    @(negedge clk); i_valid = 0; #4;
    chk("lat_k1", o_write, 0);
    nxt(); chk("lat_k2", o_write, 0);
    nxt(); chk("lat_k3", o_write, 1);
    chk("lat_addr", o_address, 1283);
    chk("lat_data", o_writedata, 8'hE3);
    nxt(); chk("lat_k4", o_write, 0);
    chk("single_count", writes_seen, base + 1);

    // stalled first write then back-to-back second
    @(negedge clk); i_waitrequest = 1;
    send(20, 30, 8'h10, 8'h20, 8'h30, 1, 1);
    send(21, 30, 8'hC0, 8'hE0, 8'h80, 1, 1);
    idle(); #4;
    for (int i = 0; i < 20 && !o_write; i++) nxt();
    chk("stall_write", o_write, 1);
    chk("stall_addr", o_address, 19220);
    repeat (4) begin
      nxt();
      chk("stall_write", o_write, 1);
      chk("stall_addr", o_address, 19220);
    end
    @(negedge clk); i_waitrequest = 0; #4;
    chk("complete_write", o_write, 1);
    nxt(); chk("b2b_write", o_write, 1);
    chk("b2b_addr", o_address, 19221);
    nxt(); chk("b2b_end", o_write, 0);

    // discarded samples
    base = writes_seen;
    send(640, 10, 8'h11, 8'h22, 8'h33, 1, 1);
    send(10, 480, 8'h11, 8'h22, 8'h33, 1, 1);
    send(5, 5, 8'h11, 8'h22, 8'h33, 0, 1);
    idle();
    repeat (6) begin
      nxt();
      chk("drop_level", o_fifo_level, 0);
      chk("drop_ovf", o_overflow_count, 0);
      chk("drop_write", o_write, 0);
    end
    chk("drop_count", writes_seen, base);

    // overflow: 1 in flight + 16 queued, 23 dropped
    base = writes_seen;
    @(negedge clk); i_waitrequest = 1;
    for (int i = 0; i < 40; i++) send(i, 100, 8'(i), 8'(255 - i), 8'(i * 3), 1, i < 17);
    idle();
    repeat (3) nxt();
    chk("ovf_count", o_overflow_count, 23);
    chk("ovf_level", o_fifo_level, 16);
    chk("ovf_write", o_write, 1);
    @(negedge clk); i_waitrequest = 0;
    wait_writes(base + 17);
    nxt(); nxt();
    chk("ovf_sb_empty", sb.size(), 0);
    chk("ovf_count_hold", o_overflow_count, 23);
    chk("ovf_drained", o_fifo_level, 0);

    // frame done on the last pixel only
    base = writes_seen;
    send(639, 479, 8'hAA, 8'h55, 8'hC3, 1, 1);
    idle();
    wait_writes(base + 1);
    nxt(); nxt();
    chk("fd_pulses_last", fd_pulses, 1);
    send(638, 479, 8'hAA, 8'h55, 8'hC3, 1, 1);
    idle();
    wait_writes(base + 2);
    nxt(); nxt();
    chk("fd_pulses_other", fd_pulses, 1);

    // reset during a stalled write with 8 queued
    @(negedge clk); i_waitrequest = 1;
    for (int i = 0; i < 9; i++) send(i, 200, 8'h40, 8'h80, 8'hC0, 1, 1);
    idle();
    repeat (4) nxt();
    chk("pre_rst_level", o_fifo_level, 8);
    chk("pre_rst_write", o_write, 1);
    @(negedge clk); reset_n = 0; #1;
    chk("mid_rst_write", o_write, 0);
    chk("mid_rst_level", o_fifo_level, 0);
    chk("mid_rst_ovf", o_overflow_count, 0);
    sb.delete();
    base = writes_seen;
    @(negedge clk); reset_n = 1; i_waitrequest = 0;
    repeat (10) begin
      nxt();
      chk("post_rst_write", o_write, 0);
    end
    chk("post_rst_count", writes_seen, base);
    send(7, 7, 8'hFF, 8'hFF, 8'hFF, 1, 1);
    idle();
    wait_writes(base + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
